mult_share_arb: RTL and testbench

- Shares one 4x4 unsigned array multiplier (combinational, 8-bit product) between NREQ requesters.
- Each requester offers an operand pair with a valid/ready handshake. A round-robin arbiter grants one requester per cycle.
- The product is registered and returned on a single response channel, tagged with the requester ID.
- Sits between the operand-producing units and the shared multiplier datapath.

---
 rtl/mult_share_arb_pkg.sv | 10 +
 rtl/mult_share_arb_if.sv | 28 ++
 rtl/mult_share_arb_mul.sv | 19 +
 rtl/mult_share_arb_rr_arbiter.sv | 29 ++
 rtl/mult_share_arb.sv | 106 ++++++++++
 tb/tb_mult_share_arb.sv | 231 +++++++++++++++++++++++
 6 files changed

// File: rtl/mult_share_arb_pkg.sv
// Shared constants and types for the shared-multiplier arbiter.
package mult_share_pkg;
  localparam int OP_W   = 4;
  localparam int PROD_W = 8;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;
endpackage

// File: rtl/mult_share_arb_if.sv
// Requester/response bus of mult_share_arb; slave is the block, master is its environment.
interface mult_share_arb_if
  import mult_share_pkg::*;
#(
  parameter int NREQ = 4
) ();
  localparam int ID_W = $clog2(NREQ);

  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0]           req_ready;
  logic [NREQ-1:0][OP_W-1:0] req_a;
  logic [NREQ-1:0][OP_W-1:0] req_b;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [PROD_W-1:0]         rsp_p;
  logic [ID_W-1:0]           rsp_id;
  logic                      busy;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_p, rsp_id, busy
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_p, rsp_id, busy
  );
endinterface

// File: rtl/mult_share_arb_mul.sv
// 4x4 unsigned array multiplier: one partial-product row per bit of b, summed.
module mul4x4_array
  import mult_share_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] p
);
  logic [OP_W-1:0][PROD_W-1:0] pp;

  for (genvar r = 0; r < OP_W; r++) begin : g_row
    assign pp[r] = PROD_W'({OP_W{b[r]}} & a) << r;
  end

  always_comb begin
    p = '0;
    for (int r = 0; r < OP_W; r++) p = p + pp[r];
  end
endmodule

// File: rtl/mult_share_arb_rr_arbiter.sv
// Round-robin search from ptr upward with wrap; gnt is qualified by en, gnt_idx is not.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] gnt_idx
);
  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt_idx  = ID_W'(idx);
        gnt[idx] = en;
      end
    end
  end
endmodule

// File: rtl/mult_share_arb.sv
// Round-robin shared 4x4 multiplier with a registered, ID-tagged response.
// MULT_SHARE_ARB_OPREG_EN adds an operand register stage (latency 2, throughput unchanged).
module mult_share_arb
  import mult_share_pkg::*;
#(
  parameter int NREQ = 4
) (
  input logic             clk,
  input logic             rst,
  mult_share_arb_if.slave bus
);
  localparam int ID_W = $clog2(NREQ);

  out_state_t        state, state_nx;
  logic [ID_W-1:0]   rr_ptr, gnt_idx, mul_id;
  logic [NREQ-1:0]   gnt;
  logic              can_load, out_adv, out_fill, xfer;
  logic [OP_W-1:0]   mul_a, mul_b;
  logic [PROD_W-1:0] prod;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (bus.req_valid),
    .ptr     (rr_ptr),
    .en      (can_load),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // req_ready follows rsp_ready combinationally through can_load.
  assign bus.req_ready = gnt;
  assign xfer          = |gnt;
  assign out_adv       = (state == OUT_EMPTY) || bus.rsp_ready;

`ifdef MULT_SHARE_ARB_OPREG_EN
  logic            op_vld;
  logic [OP_W-1:0] op_a, op_b;
  logic [ID_W-1:0] op_id;

  assign can_load = !op_vld || out_adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_vld <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      op_id  <= '0;
    end else if (can_load) begin
      op_vld <= xfer;
      if (xfer) begin
        op_a  <= bus.req_a[gnt_idx];
        op_b  <= bus.req_b[gnt_idx];
        op_id <= gnt_idx;
      end
    end
  end

  assign mul_a    = op_a;
  assign mul_b    = op_b;
  assign mul_id   = op_id;
  assign out_fill = op_vld;
  assign bus.busy = (state != OUT_EMPTY) || op_vld;
`else
  assign can_load = out_adv;
  assign mul_a    = bus.req_a[gnt_idx];
  assign mul_b    = bus.req_b[gnt_idx];
  assign mul_id   = gnt_idx;
  assign out_fill = xfer;
  assign bus.busy = (state != OUT_EMPTY);
`endif

  mul4x4_array u_mul (.a(mul_a), .b(mul_b), .p(prod));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= OUT_EMPTY;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (out_adv) state_nx = out_fill ? OUT_FULL : OUT_EMPTY;
  end

  // Draining without a refill leaves rsp_p/rsp_id at their last values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rsp_p  <= '0;
      bus.rsp_id <= '0;
    end else if (out_adv && out_fill) begin
      bus.rsp_p  <= prod;
      bus.rsp_id <= mul_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rr_ptr <= '0;
    else if (xfer) rr_ptr <= (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  assign bus.rsp_valid = (state == OUT_FULL);

  for (genvar i = 0; i < NREQ; i++) begin : g_hold
    a_op_stable: assert property (@(posedge clk) disable iff (rst)
      bus.req_valid[i] && !bus.req_ready[i] |=>
        !bus.req_valid[i] || ($stable(bus.req_a[i]) && $stable(bus.req_b[i])));
  end
endmodule

// File: tb/tb_mult_share_arb.sv
// Scoreboard bench for mult_share_arb: occupancy/round-robin reference model plus response monitor.
module tb_mult_share_arb;
  import mult_share_pkg::*;

  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_share_arb_if #(.NREQ(NREQ)) bus ();
  mult_share_arb #(.NREQ(NREQ)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int id;
    int p;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // reference model: pointer plus occupancy of operand/output stages
  int   m_ptr = 0;
  bit   m_o   = 1'b0;
  bit   m_u   = 1'b0;
  int   last_g = -1;

  bit   cur_v[NREQ];
  int   cur_a[NREQ];
  int   cur_b[NREQ];
  bit   cur_rr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_o   = 1'b0;
    m_u   = 1'b0;
    exp_q.delete();
  endtask

  // Drive one cycle of stimulus at posedge+1, check against the model, advance to next posedge+1.
  task automatic step(input string tag);
    int g;
    bit oa, cl;
    logic [NREQ-1:0] exp_rdy;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i] = cur_v[i];
      bus.req_a[i]     = OP_W'(cur_a[i]);
      bus.req_b[i]     = OP_W'(cur_b[i]);
    end
    bus.rsp_ready = cur_rr;
    #1;
    chk({tag, " rsp_valid"}, bus.rsp_valid, m_u);
    chk({tag, " busy"}, bus.busy, m_u || m_o);
    oa = !m_u || cur_rr;
`ifdef MULT_SHARE_ARB_OPREG_EN
    cl = !m_o || oa;
`else
    cl = oa;
`endif
    g = -1;
    if (cl) begin
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (m_ptr + k) % NREQ;
        if (g < 0 && cur_v[j]) g = j;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk({tag, " req_ready"}, bus.req_ready, exp_rdy);
    if (g >= 0) begin
      exp_q.push_back('{g, cur_a[g] * cur_b[g]});
      m_ptr = (g + 1) % NREQ;
    end
`ifdef MULT_SHARE_ARB_OPREG_EN
    if (oa) m_u = m_o;
    if (cl) m_o = (g >= 0);
`else
    if (oa) m_u = (g >= 0);
`endif
    last_g = g;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < NREQ; i++) cur_v[i] = 1'b0;
    cur_rr = 1'b1;
    repeat (n) step(tag);
  endtask

  task automatic rand_next(input int p_rr);
    for (int i = 0; i < NREQ; i++) begin
      if (!cur_v[i] || last_g == i) begin
        cur_v[i] = 1'($urandom_range(0, 1));
        cur_a[i] = int'($urandom_range(0, 15));
        cur_b[i] = int'($urandom_range(0, 15));
      end else if ($urandom_range(0, 9) == 0) begin
        cur_v[i] = 1'b0;
      end
    end
    cur_rr = ($urandom_range(0, 99) < p_rr);
  endtask

  // monitor: a response is consumed where rsp_valid and rsp_ready meet
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected rsp_valid", bus.rsp_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_p", bus.rsp_p, e.p);
          chk("rsp_id", bus.rsp_id, e.id);
        end
      end
    end
  end

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      cur_v[i] = 1'b0;
      cur_a[i] = 0;
      cur_b[i] = 0;
    end
    cur_rr = 1'b0;

    #2;
    chk("reset rsp_valid", bus.rsp_valid, 0);
    chk("reset rsp_p", bus.rsp_p, 0);
    chk("reset rsp_id", bus.rsp_id, 0);
    chk("reset busy", bus.busy, 0);
    #10 rst = 1'b0;
    @(posedge clk);
    #1;

    // all requesters valid, one product per cycle, ids 0,1,2,3,0...
    for (int i = 0; i < NREQ; i++) begin
      cur_v[i] = 1'b1;
      cur_a[i] = i + 1;
      cur_b[i] = 2;
    end
    cur_rr = 1'b1;
    repeat (6) step("stream");
    idle("stream drain", 3);

    // single request
    cur_v[0] = 1'b1; cur_a[0] = 3; cur_b[0] = 5; cur_rr = 1'b1;
    step("single");
    idle("single drain", 3);

    // backpressure with 15*15 held, then req1 accepted on release
    cur_v[0] = 1'b1; cur_a[0] = 15; cur_b[0] = 15; cur_rr = 1'b1;
    step("bp load");
    cur_v[0] = 1'b0;
    cur_v[1] = 1'b1; cur_a[1] = 4; cur_b[1] = 6; cur_rr = 1'b0;
    repeat (3) begin
      step("bp stall");
      if (m_u) chk("bp hold rsp_p", bus.rsp_p, 225);
    end
    cur_rr = 1'b1;
    step("bp release");
    idle("bp drain", 3);

    // wrap and skip: move pointer to 3, then only req1 valid
    cur_v[2] = 1'b1; cur_a[2] = 2; cur_b[2] = 3; cur_rr = 1'b1;
    step("ptr to 3");
    cur_v[2] = 1'b0;
    cur_v[1] = 1'b1; cur_a[1] = 7; cur_b[1] = 9;
    step("wrap skip");
    cur_v[1] = 1'b0;
    cur_v[0] = 1'b1; cur_a[0] = 1; cur_b[0] = 1;
    cur_v[3] = 1'b1; cur_a[3] = 8; cur_b[3] = 8;
    step("from ptr 2");
    cur_v[0] = 1'b0; cur_v[3] = 1'b0;
    idle("wrap drain", 4);

    // reset while a result is held
    cur_v[0] = 1'b1; cur_a[0] = 6; cur_b[0] = 7; cur_rr = 1'b1;
    step("pre-reset load");
    cur_v[0] = 1'b0; cur_rr = 1'b0;
    step("pre-reset hold");
    chk("held product", bus.rsp_p, 42);
    rst = 1'b1;
    #1;
    chk("mid reset rsp_valid", bus.rsp_valid, 0);
    chk("mid reset rsp_p", bus.rsp_p, 0);
    chk("mid reset rsp_id", bus.rsp_id, 0);
    chk("mid reset busy", bus.busy, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      cur_v[i] = 1'b1;
      cur_a[i] = 9 + i;
      cur_b[i] = 10 + i;
    end
    cur_rr = 1'b1;
    step("first after reset");
    idle("post-reset drain", 1);
    for (int i = 0; i < NREQ; i++) cur_v[i] = 1'b0;
    idle("post-reset drain", 5);

    // randomized traffic with varying backpressure
    for (int n = 0; n < 3000; n++) begin
      rand_next((n < 1500) ? 75 : 30);
      step("rand");
    end
    idle("final drain", 6);
    chk("queue drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
